// File: rtl/param_editor.sv
// Front-panel parameter editor: debounced five-button input, a 4-digit BCD value
// with committed/shadow copies, decimal-point range, edit cursor and display drive.
module param_editor #(
  parameter int unsigned DEB_CYCLES     = 250000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter logic [15:0] INIT_VAL       = 16'h1000,
  parameter logic [1:0]  INIT_RANGE     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_c,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  output logic [3:0]  num3_disp,
  output logic [3:0]  num2_disp,
  output logic [3:0]  num1_disp,
  output logic [3:0]  num0_disp,
  output logic [4:0]  contro,
  output logic [15:0] value_bcd,
  output logic        commit
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST     = DCW'(DEB_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  // Bit positions inside the button vectors; higher index wins on a tie.
  localparam int B_D = 0;
  localparam int B_U = 1;
  localparam int B_R = 2;
  localparam int B_L = 3;
  localparam int B_C = 4;

  typedef enum logic { VIEW, EDIT } state_e;
  typedef enum logic [2:0] { ACT_NONE, ACT_C, ACT_L, ACT_R, ACT_U, ACT_D } act_e;

  logic [4:0]     btn_raw;
  logic [4:0]     sync_a;
  logic [4:0]     sync_b;
  logic [4:0]     deb_level;
  logic [4:0]     press;
  logic [DCW-1:0] deb_cnt [5];

  state_e         state;
  act_e           act;
  logic [15:0]    committed;
  logic [15:0]    shadow;
  logic [1:0]     dp_sel;
  logic [1:0]     cursor;
  logic [TCW-1:0] tmo_cnt;
  logic [15:0]    disp;
  logic [3:0]     cur_digit;

  assign btn_raw = {btn_c, btn_l, btn_r, btn_u, btn_d};

  // Two-flop synchronizer followed by a mismatch-run-length debouncer per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      deb_level <= '0;
      press     <= '0;
      // NOTE: the counter array is small flop storage, not a RAM, so it is reset
      // like any other register.
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep sync_b one full cycle behind sync_a.
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]   <= '0;
          deb_level[i] <= ~deb_level[i];
          press[i]     <= ~deb_level[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Same-cycle presses collapse to the single highest-priority action.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    act = ACT_NONE;
    if (press[B_C])      act = ACT_C;
    else if (press[B_L]) act = ACT_L;
    else if (press[B_R]) act = ACT_R;
    else if (press[B_U]) act = ACT_U;
    else if (press[B_D]) act = ACT_D;
  end

  assign cur_digit = shadow[{cursor, 2'b00} +: 4];

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    if (up) return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= VIEW;
      committed <= INIT_VAL;
      shadow    <= INIT_VAL;
      value_bcd <= INIT_VAL;
      dp_sel    <= INIT_RANGE;
      cursor    <= 2'd0;
      commit    <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      commit <= 1'b0;
      case (state)
        VIEW: begin
          case (act)
            ACT_U: if (dp_sel < 2'd2) dp_sel <= dp_sel + 1'b1;
            ACT_D: if (dp_sel != 2'd0) dp_sel <= dp_sel - 1'b1;
            ACT_C: begin
              shadow  <= committed;
              cursor  <= 2'd0;
              tmo_cnt <= '0;
              state   <= EDIT;
            end
            default: ;
          endcase
        end
        EDIT: begin
          // A press in the expiry cycle restarts the idle count instead of leaving.
          if (act != ACT_NONE) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            tmo_cnt <= '0;
            state   <= VIEW;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          case (act)
            ACT_L: cursor <= cursor + 1'b1;
            ACT_R: cursor <= cursor - 1'b1;
            ACT_U: shadow[{cursor, 2'b00} +: 4] <= bcd_step(cur_digit, 1'b1);
            ACT_D: shadow[{cursor, 2'b00} +: 4] <= bcd_step(cur_digit, 1'b0);
            ACT_C: begin
              committed <= shadow;
              value_bcd <= shadow;
              commit    <= 1'b1;
              state     <= VIEW;
            end
            default: ;
          endcase
        end
        default: state <= VIEW;
      endcase
    end
  end

  // Display registers follow the editor state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp   <= INIT_VAL;
      contro <= {INIT_RANGE, 3'b000};
    end else begin
      disp   <= (state == EDIT) ? shadow : committed;
      contro <= {dp_sel, state == EDIT, cursor};
    end
  end

  assign num3_disp = disp[15:12];
  assign num2_disp = disp[11:8];
  assign num1_disp = disp[7:4];
  assign num0_disp = disp[3:0];

endmodule

// File: tb/tb_param_editor.sv
// Directed bench for param_editor with short debounce and timeout constants.
module tb_param_editor;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raw;   // {c, l, r, u, d}
  logic [3:0]  num3_disp, num2_disp, num1_disp, num0_disp;
  logic [4:0]  contro;
  logic [15:0] value_bcd;
  logic        commit;
  logic [15:0] disp;

  int n_checks = 0;
  int n_pass   = 0;
  int commit_cnt = 0;

  param_editor #(
    .DEB_CYCLES    (4),
    .TIMEOUT_CYCLES(64),
    .INIT_VAL      (16'h1000),
    .INIT_RANGE    (2'b00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_c    (raw[4]),
    .btn_l    (raw[3]),
    .btn_r    (raw[2]),
    .btn_u    (raw[1]),
    .btn_d    (raw[0]),
    .num3_disp(num3_disp),
    .num2_disp(num2_disp),
    .num1_disp(num1_disp),
    .num0_disp(num0_disp),
    .contro   (contro),
    .value_bcd(value_bcd),
    .commit   (commit)
  );

  always #5 clk = ~clk;

  assign disp = {num3_disp, num2_disp, num1_disp, num0_disp};

  always @(posedge clk) if (commit) commit_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Clean press: the action lands 7 edges after the raw edge, display one edge later.
  task automatic press(input int b);
    raw[b] = 1'b1;
    tick(7);
    raw[b] = 1'b0;
    tick(7);
  endtask

  localparam int D = 0, U = 1, R = 2, L = 3, C = 4;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    raw = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_disp",   32'(disp), 32'h1000);
    check("rst_contro", 32'(contro), 32'h00);
    check("rst_value",  32'(value_bcd), 32'h1000);
    check("rst_commit", 32'(commit), 32'h0);

    // Bouncy up button: one press, acted on 7 edges after the final rise.
    tick(2);
    raw[U] = 1'b1; tick(1);
    raw[U] = 1'b0; tick(1);
    raw[U] = 1'b1;
    tick(7);
    check("bounce_early", 32'(contro), 32'h00);
    tick(1);
    check("bounce_press", 32'(contro), 32'b01000);
    tick(10);
    check("bounce_single", 32'(contro), 32'b01000);
    raw[U] = 1'b0;
    tick(7);

    press(U); press(U); press(U);
    check("range_sat", 32'(contro), 32'b10000);

    // Edit digit 3 from 1 to 4 and commit.
    press(C);
    check("edit_enter", 32'(contro), 32'b10100);
    check("edit_disp",  32'(disp), 32'h1000);
    press(R);
    check("cursor_wrap_r", 32'(contro), 32'b10111);
    press(U); press(U); press(U);
    check("digit3_inc", 32'(disp), 32'h4000);
    check("uncommitted", 32'(value_bcd), 32'h1000);
    press(C);
    check("commit_cnt1", commit_cnt, 1);
    check("commit_value", 32'(value_bcd), 32'h4000);
    check("view_contro", 32'(contro), 32'b10011);
    check("view_disp", 32'(disp), 32'h4000);

    // Digit wrap without carry/borrow, cursor wrap left.
    press(C);
    check("reenter", 32'(contro), 32'b10100);
    for (int i = 0; i < 9; i++) press(U);
    check("digit0_nine", 32'(disp), 32'h4009);
    press(U);
    check("digit0_wrap_up", 32'(disp), 32'h4000);
    press(D);
    check("digit0_wrap_dn", 32'(disp), 32'h4009);
    press(R);
    check("cursor_to3", 32'(contro), 32'b10111);
    press(L);
    check("cursor_wrap_l", 32'(contro), 32'b10100);
    press(C);
    check("commit_4009", 32'(value_bcd), 32'h4009);
    check("commit_cnt2", commit_cnt, 2);

    // Idle timeout: the u action edge is A; expiry edge is A+64, display A+65.
    press(C);
    press(U);            // returns at A+7
    tick(56);            // A+63
    check("tmo_still_edit", 32'(contro), 32'b10100);
    check("tmo_shadow", 32'(disp), 32'h4000);
    tick(2);             // A+65
    check("tmo_view", 32'(contro), 32'b10000);
    check("tmo_disp", 32'(disp), 32'h4009);
    check("tmo_value", 32'(value_bcd), 32'h4009);
    check("tmo_no_commit", commit_cnt, 2);

    // Press landing on the expiry edge keeps the editor in EDIT.
    press(C);            // c acted at M+7, returns at M+14
    tick(50);            // M+64: u acts at M+71, idle count 63
    press(U);
    check("tmo_press_edit", 32'(contro), 32'b10100);
    check("tmo_press_disp", 32'(disp), 32'h4000);

    // Centre and left debounced together: commit only.
    raw[C] = 1'b1;
    raw[L] = 1'b1;
    tick(7);
    raw[C] = 1'b0;
    raw[L] = 1'b0;
    tick(7);
    check("tie_commit_cnt", commit_cnt, 3);
    check("tie_value", 32'(value_bcd), 32'h4000);
    check("tie_contro", 32'(contro), 32'b10000);

    // Reset in the middle of an edit.
    press(C);
    press(U);
    check("pre_rst_disp", 32'(disp), 32'h4001);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_value", 32'(value_bcd), 32'h1000);
    check("mid_rst_disp", 32'(disp), 32'h1000);
    check("mid_rst_contro", 32'(contro), 32'h00);
    check("mid_rst_commit", 32'(commit), 32'h0);
    tick(3);
    check("mid_rst_no_pulse", commit_cnt, 3);
    check("mid_rst_hold", 32'(value_bcd), 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
